// File: rtl/lap_stopwatch.sv
// -----------------------------------------------------------------------------
// lap_stopwatch
//   BCD stopwatch (MM:SS.cc) with a run/pause/clear control FSM and a circular
//   lap memory. Any stored lap can be shown on the display while the live count
//   keeps advancing underneath. The output feeds the 7-segment decoders.
//
// Parameters
//   CLK_DIV    clock cycles per centisecond tick (>= 2)
//   LAP_DEPTH  lap entries, power of 2 (>= 2)
//   MIN_MAX    largest minute value before the count wraps (1..99)
//
// Ports
//   clock        system clock
//   reset        synchronous, active-high reset
//   start_pulse  one-cycle pulse, toggles run/pause (IDLE -> RUN)
//   clear_pulse  one-cycle pulse, zero the count and the lap memory
//   lap_pulse    one-cycle pulse, capture a lap (accepted in RUN only)
//   recall_en    level, 1 = display a lap entry instead of the live count
//   recall_sel   lap index, 0 = most recent
//   digits       registered BCD {m_d, m_u, s_d, s_u, cs_d, cs_u}
//   running      registered, 1 while in RUN
//   lap_count    valid lap entries, saturates at LAP_DEPTH
//   overflow     one-cycle pulse when MIN_MAX:59.99 wraps to 00:00.00
//
// Build option
//   LAP_SPLIT_DELTA_EN  when defined, each lap entry holds the split time
//                       (count minus the count at the previous accepted lap)
//                       instead of the absolute elapsed time.
// -----------------------------------------------------------------------------
module lap_stopwatch #(
  parameter int CLK_DIV   = 500000,
  parameter int LAP_DEPTH = 4,
  parameter int MIN_MAX   = 59
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start_pulse,
  input  logic                         clear_pulse,
  input  logic                         lap_pulse,
  input  logic                         recall_en,
  input  logic [$clog2(LAP_DEPTH)-1:0] recall_sel,
  output logic [23:0]                  digits,
  output logic                         running,
  output logic [$clog2(LAP_DEPTH):0]   lap_count,
  output logic                         overflow
);

  localparam int PTR_W = $clog2(LAP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PRE_W = $clog2(CLK_DIV);

  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LAP_FULL = CNT_W'(LAP_DEPTH);
  localparam logic [3:0]       MIN_T    = 4'(MIN_MAX / 10);
  localparam logic [3:0]       MIN_U    = 4'(MIN_MAX % 10);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  // ---------------------------------------------------------------------------
  // BCD increment across the mixed radices; bit 24 flags the full wrap.
  // NOTE: function locals are combinational temporaries, so blocking '=' is
  // correct here; only the clocked block below uses '<='.
  // ---------------------------------------------------------------------------
  function automatic logic [24:0] bcd_inc(input logic [23:0] c);
    logic [3:0] mt, mu, st, su, ct, cu;
    logic       wrap;
    {mt, mu, st, su, ct, cu} = c;
    wrap = 1'b0;
    if (cu != 4'd9) cu = cu + 4'd1;
    else begin
      cu = 4'd0;
      if (ct != 4'd9) ct = ct + 4'd1;
      else begin
        ct = 4'd0;
        if (su != 4'd9) su = su + 4'd1;
        else begin
          su = 4'd0;
          if (st != 4'd5) st = st + 4'd1;
          else begin
            st = 4'd0;
            if (mt == MIN_T && mu == MIN_U) begin
              mt   = 4'd0;
              mu   = 4'd0;
              wrap = 1'b1;
            end else if (mu != 4'd9) begin
              mu = mu + 4'd1;
            end else begin
              mu = 4'd0;
              mt = mt + 4'd1;
            end
          end
        end
      end
    end
    return {wrap, mt, mu, st, su, ct, cu};
  endfunction

`ifdef LAP_SPLIT_DELTA_EN
  // a - b digit by digit with borrow; seconds-tens uses radix 6, the rest 10.
  // A borrow out of the minutes-tens digit is dropped.
  function automatic logic [23:0] bcd_sub(input logic [23:0] a, input logic [23:0] b);
    logic [23:0] r;
    logic        borrow;
    logic [4:0]  diff;
    logic [4:0]  radix;
    r      = '0;
    borrow = 1'b0;
    for (int i = 0; i < 6; i++) begin
      radix = (i == 3) ? 5'd6 : 5'd10;
      diff  = {1'b0, a[i*4 +: 4]} - {1'b0, b[i*4 +: 4]} - {4'd0, borrow};
      if (diff[4]) begin
        diff   = diff + radix;
        borrow = 1'b1;
      end else begin
        borrow = 1'b0;
      end
      r[i*4 +: 4] = diff[3:0];
    end
    return r;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [PRE_W-1:0] r_presc;
  logic [23:0]      r_cnt;
  logic [23:0]      r_lap_mem [LAP_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_lap_count;
  logic [23:0]      r_digits;
  logic             r_running;
  logic             r_overflow;
`ifdef LAP_SPLIT_DELTA_EN
  logic [23:0]      r_last_lap;
`endif

  logic             w_tick;
  logic [24:0]      w_inc;
  logic             w_lap_accept;
  logic [23:0]      w_lap_value;
  logic [PTR_W-1:0] w_rd_idx;
  logic [23:0]      w_recall;

  assign w_tick       = (r_state == ST_RUN) && (r_presc == PRE_MAX);
  assign w_inc        = bcd_inc(r_cnt);
  assign w_lap_accept = lap_pulse && (r_state == ST_RUN);

  // Laps sample the pre-tick count, so a lap coincident with a tick records
  // the value still on display.
`ifdef LAP_SPLIT_DELTA_EN
  assign w_lap_value  = bcd_sub(r_cnt, r_last_lap);
`else
  assign w_lap_value  = r_cnt;
`endif

  // Most recent entry sits just behind the write pointer; the pointer width
  // makes the subtraction wrap modulo LAP_DEPTH.
  assign w_rd_idx = r_wr_ptr - PTR_W'(1) - recall_sel;
  assign w_recall = ({1'b0, recall_sel} < r_lap_count) ? r_lap_mem[w_rd_idx] : '0;

  // NOTE: all state uses non-blocking '<=' so every register samples the
  // pre-edge values, which is what makes "lap captures the pre-tick count"
  // and "start + tick applies the tick then pauses" fall out naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_presc     <= '0;
      r_cnt       <= '0;
      r_wr_ptr    <= '0;
      r_lap_count <= '0;
      r_digits    <= '0;
      r_running   <= 1'b0;
      r_overflow  <= 1'b0;
`ifdef LAP_SPLIT_DELTA_EN
      r_last_lap  <= '0;
`endif
      // NOTE: the lap memory is a handful of registers that must read back
      // as zero after reset, so it is reset explicitly rather than left to RAM.
      for (int i = 0; i < LAP_DEPTH; i++) r_lap_mem[i] <= '0;
    end else begin
      r_overflow <= 1'b0;

      if (clear_pulse) begin
        // Clear outranks lap and start; both are dropped this cycle.
        r_state     <= ST_IDLE;
        r_presc     <= '0;
        r_cnt       <= '0;
        r_wr_ptr    <= '0;
        r_lap_count <= '0;
`ifdef LAP_SPLIT_DELTA_EN
        r_last_lap  <= '0;
`endif
        for (int i = 0; i < LAP_DEPTH; i++) r_lap_mem[i] <= '0;
      end else begin
        if (w_lap_accept) begin
          r_lap_mem[r_wr_ptr] <= w_lap_value;
          r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
          if (r_lap_count != LAP_FULL) r_lap_count <= r_lap_count + CNT_W'(1);
`ifdef LAP_SPLIT_DELTA_EN
          r_last_lap          <= r_cnt;
`endif
        end

        if (w_tick) begin
          r_cnt      <= w_inc[23:0];
          r_overflow <= w_inc[24];
        end

        // Prescaler holds outside RUN so a pause keeps the sub-tick phase.
        if (r_state == ST_RUN) begin
          r_presc <= (r_presc == PRE_MAX) ? '0 : r_presc + PRE_W'(1);
        end

        if (start_pulse) begin
          case (r_state)
            ST_IDLE:  r_state <= ST_RUN;
            ST_RUN:   r_state <= ST_PAUSE;
            ST_PAUSE: r_state <= ST_RUN;
            default:  r_state <= ST_IDLE;
          endcase
        end
      end

      // Display follows its sources with one register stage.
      r_digits  <= recall_en ? w_recall : r_cnt;
      r_running <= (r_state == ST_RUN);
    end
  end

  assign digits    = r_digits;
  assign running   = r_running;
  assign lap_count = r_lap_count;
  assign overflow  = r_overflow;

endmodule
